// File: rtl/bti_sram_slv.sv
// BTI slave bridging a request/response channel to a word-organised on-chip SRAM.
// Define BTI_SRAM_ALIGN_CHK_EN to reject accesses with addr[1:0] != 0.
module bti_sram_slv #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RSP_DEPTH = 2,
  parameter int unsigned TID_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // request channel
  input  logic             bti_req_vld_i,
  output logic             bti_req_rdy_o,
  input  logic [TID_W-1:0] bti_req_tid_i,
  input  logic             bti_req_cmd_i,
  input  logic [31:0]      bti_req_addr_i,
  input  logic [31:0]      bti_req_data_i,
  input  logic [3:0]       bti_req_strobe_i,
  // response channel
  output logic             bti_rsp_vld_o,
  input  logic             bti_rsp_rdy_i,
  output logic [TID_W-1:0] bti_rsp_tid_o,
  output logic [31:0]      bti_rsp_data_o,
  output logic             bti_rsp_ok_o
);

  localparam logic BTI_CMD_READ  = 1'b0;
  localparam logic BTI_CMD_WRITE = 1'b1;

  localparam int unsigned Words = MEM_BYTES / 4;
  localparam int unsigned AddrW = $clog2(MEM_BYTES);
  localparam int unsigned IdxW  = (AddrW > 2) ? AddrW - 2 : 1;
  localparam int unsigned CntW  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PtrW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  // Address decode
  logic [31:0]     off;
  logic            in_range;
  logic            acc_ok;
  logic [IdxW-1:0] idx;

  assign off      = bti_req_addr_i - BASE_ADDR;
  assign in_range = (bti_req_addr_i >= BASE_ADDR) && (off < 32'(MEM_BYTES));
  assign idx      = IdxW'(off >> 2);

`ifdef BTI_SRAM_ALIGN_CHK_EN
  assign acc_ok = in_range && (bti_req_addr_i[1:0] == 2'b00);
`else
  assign acc_ok = in_range;
`endif

  // SRAM storage, deliberately not reset
  logic [31:0] mem_q [Words];
  logic [31:0] rd_word;
  logic        push;
  logic        pop;
  logic        mem_we;

  assign push    = bti_req_vld_i && bti_req_rdy_o;
  assign pop     = bti_rsp_vld_o && bti_rsp_rdy_i;
  assign mem_we  = push && acc_ok && (bti_req_cmd_i == BTI_CMD_WRITE);
  assign rd_word = mem_q[idx];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bti_req_strobe_i[b]) mem_q[idx][8*b +: 8] <= bti_req_data_i[8*b +: 8];
      end
    end
  end

  // Response FIFO
  logic [TID_W-1:0] fifo_tid_q  [RSP_DEPTH];
  logic [31:0]      fifo_data_q [RSP_DEPTH];
  logic             fifo_ok_q   [RSP_DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [31:0]      push_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(RSP_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    push_data = '0;
    if (acc_ok && (bti_req_cmd_i == BTI_CMD_READ)) push_data = rd_word;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_tid_q[wr_ptr_q]  <= bti_req_tid_i;
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_ok_q[wr_ptr_q]   <= acc_ok;
    end
  end

  assign bti_req_rdy_o  = (cnt_q < CntW'(RSP_DEPTH));
  assign bti_rsp_vld_o  = (cnt_q != '0);
  assign bti_rsp_tid_o  = fifo_tid_q[rd_ptr_q];
  assign bti_rsp_data_o = fifo_data_q[rd_ptr_q];
  assign bti_rsp_ok_o   = fifo_ok_q[rd_ptr_q];

endmodule

// File: tb/tb_bti_sram_slv.sv
// Directed self-checking bench for bti_sram_slv (default parameters).
module tb_bti_sram_slv;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  logic        clk;
  logic        rst_n;
  logic        req_vld;
  logic        req_rdy;
  logic [3:0]  req_tid;
  logic        req_cmd;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_strobe;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [3:0]  rsp_tid;
  logic [31:0] rsp_data;
  logic        rsp_ok;

  int n_chk;
  int n_fail;

  bti_sram_slv dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bti_req_vld_i    (req_vld),
    .bti_req_rdy_o    (req_rdy),
    .bti_req_tid_i    (req_tid),
    .bti_req_cmd_i    (req_cmd),
    .bti_req_addr_i   (req_addr),
    .bti_req_data_i   (req_data),
    .bti_req_strobe_i (req_strobe),
    .bti_rsp_vld_o    (rsp_vld),
    .bti_rsp_rdy_i    (rsp_rdy),
    .bti_rsp_tid_o    (rsp_tid),
    .bti_rsp_data_o   (rsp_data),
    .bti_rsp_ok_o     (rsp_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] tid, input logic cmd, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] strobe);
    req_vld    = 1'b1;
    req_tid    = tid;
    req_cmd    = cmd;
    req_addr   = addr;
    req_data   = data;
    req_strobe = strobe;
  endtask

  task automatic idle();
    req_vld = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic [3:0] tid, input logic [31:0] data,
                         input logic ok);
    chk({tag, ".vld"}, 64'(rsp_vld), 64'(1'b1));
    chk({tag, ".tid"}, 64'(rsp_tid), 64'(tid));
    chk({tag, ".data"}, 64'(rsp_data), 64'(data));
    chk({tag, ".ok"}, 64'(rsp_ok), 64'(ok));
  endtask

  initial begin
    logic [31:0] wd;
    logic [31:0] last_wd;
    logic [31:0] addr;
    n_chk   = 0;
    n_fail  = 0;
    wd      = '0;
    last_wd = '0;
    rst_n   = 1'b0;
    rsp_rdy = 1'b1;
    req_vld = 1'b0;
    req_tid = '0;
    req_cmd = RD;
    req_addr = '0;
    req_data = '0;
    req_strobe = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: reset state, write then read-after-write
    chk("rst.req_rdy", 64'(req_rdy), 64'(1'b1));
    chk("rst.rsp_vld", 64'(rsp_vld), 64'(1'b0));
    req(4'd1, WR, 32'h10, 32'hDEAD_BEEF, 4'hF);
    tick();
    chk_rsp("t1.wr", 4'd1, 32'h0, 1'b1);
    req(4'd2, RD, 32'h10, 32'h0, 4'h0);
    tick();
    chk_rsp("t1.rd", 4'd2, 32'hDEAD_BEEF, 1'b1);

    // 2: partial strobe, then zero-strobe no-op write
    req(4'd3, WR, 32'h10, 32'h00AA_0055, 4'b0101);
    tick();
    chk_rsp("t2.wr", 4'd3, 32'h0, 1'b1);
    req(4'd4, RD, 32'h10, 32'h0, 4'h0);
    tick();
    chk_rsp("t2.rd", 4'd4, 32'hDEAA_BE55, 1'b1);
    req(4'd5, WR, 32'h10, 32'hFFFF_FFFF, 4'b0000);
    tick();
    chk_rsp("t2.nop", 4'd5, 32'h0, 1'b1);
    req(4'd6, RD, 32'h10, 32'h0, 4'hF);
    tick();
    chk_rsp("t2.rd2", 4'd6, 32'hDEAA_BE55, 1'b1);
    idle();
    tick();
    chk("t2.drain", 64'(rsp_vld), 64'(1'b0));

    // 3: backpressure fills the FIFO, then drains in order
    rsp_rdy = 1'b0;
    req(4'd1, RD, 32'h10, 32'h0, 4'h0);
    tick();
    req(4'd2, RD, 32'h10, 32'h0, 4'h0);
    tick();
    chk("t3.full_rdy", 64'(req_rdy), 64'(1'b0));
    req(4'd3, RD, 32'h10, 32'h0, 4'h0);
    tick();
    chk("t3.full_rdy2", 64'(req_rdy), 64'(1'b0));
    chk_rsp("t3.hold", 4'd1, 32'hDEAA_BE55, 1'b1);
    tick();
    chk_rsp("t3.hold2", 4'd1, 32'hDEAA_BE55, 1'b1);
    rsp_rdy = 1'b1;
    tick();
    chk_rsp("t3.h2", 4'd2, 32'hDEAA_BE55, 1'b1);
    chk("t3.rdy_back", 64'(req_rdy), 64'(1'b1));
    tick();
    idle();
    chk_rsp("t3.h3", 4'd3, 32'hDEAA_BE55, 1'b1);
    chk("t3.cnt", 64'(dut.cnt_q), 64'd1);
    tick();
    chk("t3.empty", 64'(rsp_vld), 64'(1'b0));

    // 4: out-of-range read/write leave word 0 intact
    req(4'd5, WR, 32'h0, 32'hCAFE_F00D, 4'hF);
    tick();
    req(4'd6, RD, 32'h0001_0000, 32'h0, 4'h0);
    tick();
    chk_rsp("t4.oor_rd", 4'd6, 32'h0, 1'b0);
    req(4'd7, WR, 32'h0001_0000, 32'h1234_5678, 4'hF);
    tick();
    chk_rsp("t4.oor_wr", 4'd7, 32'h0, 1'b0);
    req(4'd8, RD, 32'h0, 32'h0, 4'h0);
    tick();
    chk_rsp("t4.word0", 4'd8, 32'hCAFE_F00D, 1'b1);
    idle();
    tick();

    // 5: 100 alternating write/read transactions at full rate
    for (int i = 0; i < 100; i++) begin
      addr = 32'h100 + 32'((i / 2) * 4);
      if (i % 2 == 0) begin
        wd = 32'hA5A5_0000 + 32'(i * 32'h0001_0103);
        req(4'(i), WR, addr, wd, 4'hF);
      end else begin
        req(4'(i), RD, addr, 32'h0, 4'h0);
      end
      chk("t5.req_rdy", 64'(req_rdy), 64'(1'b1));
      tick();
      if (i % 2 == 0) begin
        last_wd = wd;
        chk_rsp("t5.wr", 4'(i), 32'h0, 1'b1);
      end else begin
        chk_rsp("t5.rd", 4'(i), last_wd, 1'b1);
      end
    end
    idle();
    tick();

    // 6: reset with queued responses
    rsp_rdy = 1'b0;
    req(4'd1, RD, 32'h10, 32'h0, 4'h0);
    tick();
    req(4'd2, RD, 32'h10, 32'h0, 4'h0);
    tick();
    idle();
    chk("t6.queued", 64'(rsp_vld), 64'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6.vld_drop", 64'(rsp_vld), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6.req_rdy", 64'(req_rdy), 64'(1'b1));
    chk("t6.vld", 64'(rsp_vld), 64'(1'b0));
    chk("t6.cnt", 64'(dut.cnt_q), 64'd0);
    rsp_rdy = 1'b1;
    req(4'd9, RD, 32'h12, 32'h0, 4'h0);
    tick();
    idle();
`ifdef BTI_SRAM_ALIGN_CHK_EN
    chk_rsp("t6.misalign", 4'd9, 32'h0, 1'b0);
`else
    chk_rsp("t6.misalign", 4'd9, 32'hDEAA_BE55, 1'b1);
`endif
    tick();
    chk("t6.empty", 64'(rsp_vld), 64'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
